// File: rtl/dout_display.sv
// Seven-segment formatter for the CPU output byte: unsigned/signed decimal via
// an 8-step double-dabble, or two hex digits. Outputs are registered, active-low.
module dout_display #(
  parameter int unsigned LEAD_BLANK = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Din,
  input  logic       Dval,
  input  logic [1:0] Mode,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  state_t      state_q, state_d;
  logic [7:0]  din_lat_q, din_lat_d;
  logic [1:0]  mode_lat_q, mode_lat_d;
  logic        valid_q, valid_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  hex3_q, hex3_d, hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
  logic [10:0] adj;
  logic [3:0]  hund, tens, ones;
  logic        blank_h, blank_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d    = state_q;
    din_lat_d  = din_lat_q;
    mode_lat_d = mode_lat_q;
    valid_d    = valid_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    hex3_d     = hex3_q;
    hex2_d     = hex2_q;
    hex1_d     = hex1_q;
    hex0_d     = hex0_q;

    // Hundreds never exceeds 2 for an 8-bit magnitude, so it needs no adjust.
    adj  = {bcd_q[10:8], add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    hund = bcd_q[11:8];
    tens = bcd_q[7:4];
    ones = bcd_q[3:0];
    blank_h = (LEAD_BLANK != 0) && (hund == 4'd0);
    blank_t = blank_h && (tens == 4'd0);

    case (state_q)
      IDLE: begin
        if (!Dval) begin
          hex3_d  = SEG_BLANK;
          hex2_d  = SEG_BLANK;
          hex1_d  = SEG_BLANK;
          hex0_d  = SEG_BLANK;
          valid_d = 1'b0;
        end else if (!valid_q || Din != din_lat_q || Mode != mode_lat_q) begin
          din_lat_d  = Din;
          mode_lat_d = Mode;
          valid_d    = 1'b1;
          mag_d      = (Mode == 2'b01 && Din[7]) ? (~Din + 8'd1) : Din;
          bcd_d      = 12'd0;
          cnt_d      = 3'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {adj, mag_q[7]};
        mag_d = {mag_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        hex3_d = SEG_BLANK;
        hex2_d = blank_h ? SEG_BLANK : glyph(hund);
        hex1_d = blank_t ? SEG_BLANK : glyph(tens);
        hex0_d = glyph(ones);
        case (mode_lat_q)
          2'b01: if (din_lat_q[7]) hex3_d = SEG_MINUS;
          2'b10: begin
            hex2_d = SEG_BLANK;
            hex1_d = glyph(din_lat_q[7:4]);
            hex0_d = glyph(din_lat_q[3:0]);
          end
          2'b11: begin
            hex2_d = SEG_BLANK;
            hex1_d = SEG_BLANK;
            hex0_d = SEG_BLANK;
          end
          default: ;
        endcase
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      din_lat_q  <= 8'd0;
      mode_lat_q <= 2'd0;
      valid_q    <= 1'b0;
      mag_q      <= 8'd0;
      bcd_q      <= 12'd0;
      cnt_q      <= 3'd0;
      hex3_q     <= SEG_BLANK;
      hex2_q     <= SEG_BLANK;
      hex1_q     <= SEG_BLANK;
      hex0_q     <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      din_lat_q  <= din_lat_d;
      mode_lat_q <= mode_lat_d;
      valid_q    <= valid_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      hex3_q     <= hex3_d;
      hex2_q     <= hex2_d;
      hex1_q     <= hex1_d;
      hex0_q     <= hex0_d;
    end
  end

  assign HEX3 = hex3_q;
  assign HEX2 = hex2_q;
  assign HEX1 = hex1_q;
  assign HEX0 = hex0_q;
  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_dout_display.sv
// Directed bench for dout_display: vector table for the formats plus hand-timed
// sequences for mid-conversion input change and reset abort.
module tb_dout_display;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Din   = 8'd0;
  logic       Dval  = 1'b0;
  logic [1:0] Mode  = 2'd0;
  logic [6:0] h3, h2, h1, h0, z3, z2, z1, z0;
  logic       busy, busy_z;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [27:0] ALL_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

  always #5 Clock = ~Clock;

  dout_display #(.LEAD_BLANK(1)) u_dut (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Dval(Dval), .Mode(Mode),
    .HEX3(h3), .HEX2(h2), .HEX1(h1), .HEX0(h0), .Busy(busy)
  );

  dout_display #(.LEAD_BLANK(0)) u_lb0 (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Dval(Dval), .Mode(Mode),
    .HEX3(z3), .HEX2(z2), .HEX1(z1), .HEX0(z0), .Busy(busy_z)
  );

  typedef struct {
    logic [7:0]  din;
    logic [1:0]  mode;
    logic [27:0] exp;
    logic [27:0] exp_lb0;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Assumes inputs were presented before the capture edge; returns just after the last busy edge.
  task automatic wait_conversion(input string name);
    int cyc = 0;
    @(posedge Clock); #1;
    while (busy && cyc < 20) begin
      cyc++;
      @(posedge Clock); #1;
    end
    check({name, " busy cycles"}, cyc, 9);
  endtask

  initial begin
    vecs[0]  = '{8'd200, 2'b00, {7'h7F,7'h24,7'h40,7'h40}, {7'h7F,7'h24,7'h40,7'h40}};
    vecs[1]  = '{8'h80,  2'b01, {7'h3F,7'h79,7'h24,7'h00}, {7'h3F,7'h79,7'h24,7'h00}};
    vecs[2]  = '{8'hFF,  2'b01, {7'h3F,7'h7F,7'h7F,7'h79}, {7'h3F,7'h40,7'h40,7'h79}};
    vecs[3]  = '{8'h07,  2'b00, {7'h7F,7'h7F,7'h7F,7'h78}, {7'h7F,7'h40,7'h40,7'h78}};
    vecs[4]  = '{8'hAF,  2'b10, {7'h7F,7'h7F,7'h08,7'h0E}, {7'h7F,7'h7F,7'h08,7'h0E}};
    vecs[5]  = '{8'd255, 2'b00, {7'h7F,7'h24,7'h12,7'h12}, {7'h7F,7'h24,7'h12,7'h12}};
    vecs[6]  = '{8'h7F,  2'b01, {7'h7F,7'h79,7'h24,7'h78}, {7'h7F,7'h79,7'h24,7'h78}};
    vecs[7]  = '{8'h00,  2'b00, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h7F,7'h40,7'h40,7'h40}};
    vecs[8]  = '{8'd10,  2'b00, {7'h7F,7'h7F,7'h79,7'h40}, {7'h7F,7'h40,7'h79,7'h40}};
    vecs[9]  = '{8'd100, 2'b00, {7'h7F,7'h79,7'h40,7'h40}, {7'h7F,7'h79,7'h40,7'h40}};
    vecs[10] = '{8'h55,  2'b11, ALL_BLANK,                 ALL_BLANK};
    vecs[11] = '{8'hF6,  2'b01, {7'h3F,7'h7F,7'h79,7'h40}, {7'h3F,7'h40,7'h79,7'h40}};
    vecs[12] = '{8'h3C,  2'b10, {7'h7F,7'h7F,7'h30,7'h46}, {7'h7F,7'h7F,7'h30,7'h46}};
    vecs[13] = '{8'd129, 2'b00, {7'h7F,7'h79,7'h24,7'h10}, {7'h7F,7'h79,7'h24,7'h10}};

    // Reset, then idle with Dval low for 50 cycles.
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check("reset hex", {h3, h2, h1, h0}, ALL_BLANK);
    check("reset busy", busy, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      check($sformatf("idle hold %0d", i), {busy, h3, h2, h1, h0}, {1'b0, ALL_BLANK});
    end

    foreach (vecs[i]) begin
      @(negedge Clock);
      Dval = 1'b0;
      @(negedge Clock);
      check($sformatf("v%0d pre-blank", i), {h3, h2, h1, h0}, ALL_BLANK);
      Din  = vecs[i].din;
      Mode = vecs[i].mode;
      Dval = 1'b1;
      wait_conversion($sformatf("v%0d", i));
      check($sformatf("v%0d hex", i), {h3, h2, h1, h0}, vecs[i].exp);
      check($sformatf("v%0d hex lb0", i), {z3, z2, z1, z0}, vecs[i].exp_lb0);
      repeat (3) @(posedge Clock);
      #1;
      check($sformatf("v%0d hold", i), {busy, h3, h2, h1, h0}, {1'b0, vecs[i].exp});
    end

    // Dval drop from a displayed hex value blanks on the very next edge.
    @(negedge Clock);
    Dval = 1'b0;
    @(posedge Clock); #1;
    check("dval drop blank", {h3, h2, h1, h0}, ALL_BLANK);

    // Din changes 5 -> 9 at E3: first result shows 5, retrigger shows 9 by E19.
    @(negedge Clock);
    Din = 8'd5; Mode = 2'b00; Dval = 1'b1;
    @(posedge Clock);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Din = 8'd9;
    repeat (7) @(posedge Clock);
    #1;
    check("retrig E9", {busy, h3, h2, h1, h0}, {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    @(posedge Clock); #1;
    check("retrig E10 busy", busy, 1);
    repeat (9) @(posedge Clock);
    #1;
    check("retrig E19", {busy, h3, h2, h1, h0}, {1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h10});

    // Reset at E4 aborts the conversion; nothing appears until Dval returns.
    @(negedge Clock);
    Dval = 1'b0;
    @(negedge Clock);
    Din = 8'h42; Mode = 2'b00; Dval = 1'b1;
    @(posedge Clock);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    Dval  = 1'b0;
    @(posedge Clock); #1;
    check("abort E4", {busy, h3, h2, h1, h0}, {1'b0, ALL_BLANK});
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      check($sformatf("abort hold %0d", i), {busy, h3, h2, h1, h0}, {1'b0, ALL_BLANK});
    end
    Dval = 1'b1;
    wait_conversion("post-abort");
    check("post-abort hex", {h3, h2, h1, h0}, {7'h7F, 7'h7F, 7'h02, 7'h02});
    check("post-abort hex lb0", {z3, z2, z1, z0}, {7'h7F, 7'h40, 7'h02, 7'h02});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dout_display.md
DOUT_DISPLAY -- requirements
Module: dout_display

Interface
REQ-001 SHALL have parameter: LEAD_BLANK, default 1, blank leading zero decimal digits (ones digit never blanked).
REQ-002 SHALL have port: Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: Din  input  8  data byte from the CPU Dout output.
REQ-005 SHALL have port: Dval  input  1  data-valid from CPU Dval; 0 = display blank.
REQ-006 SHALL have port: Mode  input  2  format select: 00 unsigned decimal, 01 signed decimal, 10 hex, 11 blank.
REQ-007 SHALL have ports: HEX3, HEX2, HEX1, HEX0  output  7 each  registered seven-segment codes, active-low, bit0=a..bit6=g.
REQ-008 SHALL have port: Busy  output  1  high while a conversion is in progress.

Function
REQ-009 SHALL keep a latched copy {Din, Mode, valid} of the last converted input.
REQ-010 SHALL use FSM states IDLE, SHIFT, DONE; Busy = (state != IDLE).
REQ-011 In IDLE with Dval=1 and {Din, Mode} differing from the latch, or latch valid=0: SHALL capture Din and Mode into the latch, set valid=1, load the work register, clear the 3-bit iteration count, and go to SHIFT (capture edge E0).
REQ-012 In IDLE with Dval=0: SHALL drive all HEX outputs to 7'h7F on the next edge, clear latch valid, and start no conversion.
REQ-013 SHALL form the work magnitude as the 8-bit two's-complement negation of Din when Mode=01 and Din[7]=1, and as Din otherwise; 8'h80 yields 128.
REQ-014 SHALL perform one double-dabble step per SHIFT cycle: add 3 to each 4-bit BCD nibble >= 5, then shift {BCD[11:0], magnitude} left by 1.
REQ-015 SHALL leave SHIFT for DONE after exactly 8 iterations (edges E1..E8).
REQ-016 In DONE (edge E9): SHALL write HEX3..HEX0 from the latched value and the BCD result, then return to IDLE; output latency is 9 edges after capture, for every Mode.
REQ-017 Mode 00: SHALL drive HEX3=blank, HEX2=hundreds, HEX1=tens, HEX0=ones.
REQ-018 Mode 01: SHALL drive HEX3=minus (7'h3F) if Din[7]=1, else blank; HEX2..HEX0 show the magnitude digits.
REQ-019 Mode 10: SHALL drive HEX3=HEX2=blank, HEX1=Din[7:4], HEX0=Din[3:0], with no blanking.
REQ-020 Mode 11: SHALL drive all four outputs blank.
REQ-021 If LEAD_BLANK=1 in decimal modes: SHALL blank the hundreds digit if zero, and blank the tens digit if both hundreds and tens are zero.
REQ-022 SHALL use glyphs 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex), blank = 7F, minus = 3F.
REQ-023 SHALL ignore changes to Din, Mode or Dval while Busy; on return to IDLE the latch compare SHALL retrigger, so the display settles on the latest stable input within 20 cycles.
REQ-024 SHALL hold the HEX outputs unchanged between DONE updates, except for the blanking described in REQ-012.

Reset
REQ-025 On Reset=1 at a rising edge: SHALL set state=IDLE, HEX3..HEX0=7'h7F, Busy=0, latch valid=0, and iteration count=0.
REQ-026 Reset asserted mid-conversion SHALL abort it without updating the displayed value beyond the blank reset value; reset SHALL take priority over all other actions.

Verification
REQ-027 Reset with Dval=0 -> all HEX=7F, Busy=0; stays so for 50 cycles.
REQ-028 Din=200, Mode=00, Dval=1 -> Busy=1 for 9 cycles, then HEX3=7F, HEX2=24, HEX1=40, HEX0=40.
REQ-029 Din=8'h80, Mode=01 -> HEX3=3F, HEX2=79, HEX1=24, HEX0=00; Din=8'hFF, Mode=01 -> HEX3=3F, HEX2=7F, HEX1=7F, HEX0=79.
REQ-030 Din=8'h07, Mode=00, LEAD_BLANK=1 -> HEX2=HEX1=7F, HEX0=78; with LEAD_BLANK=0 -> HEX2=HEX1=40.
REQ-031 Din=8'hAF, Mode=10 -> HEX3=HEX2=7F, HEX1=08, HEX0=0E; then Dval=0 -> all 7F on the next edge.
REQ-032 Din=5 changed to 9 at E3 of a conversion -> HEX0=12 at E9, retrigger, HEX0=10 by E19; Reset at E4 of a conversion -> all 7F, Busy=0, no later update until the next change.
